// File: rtl/lif_step_scheduler.sv
// lif_step_scheduler
//   Time-multiplexes one shared LIF update datapath across NUM_NEURONS neurons. Holds the
//   per-neuron membrane and input-current registers. On each tick it issues one datapath
//   request per neuron in index order, writes the results back and publishes the spike vector.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   tick                     start one timestep (1-cycle pulse)
//   cur_wr_en/addr/data      input current register write, accepted in any state
//   dp_req, dp_mem, dp_cur   datapath request, held until dp_ack
//   dp_ack, dp_mem_next,     datapath result (dp_ack may coincide with the first dp_req cycle)
//   dp_spike
//   spike_vec, spike_valid   spikes of the last completed timestep, update strobe
//   busy                     timestep in progress
//   overrun                  tick arrived while a timestep was still in progress
//
// Configuration
//   REFRACTORY_EN            when defined, a neuron that spiked is skipped (membrane held at 0)
//                            for REFRACT_STEPS following timesteps.

module lif_step_scheduler #(
    parameter int unsigned NUM_NEURONS   = 4,
    parameter int unsigned DW            = 8,
    parameter int unsigned AW            = $clog2(NUM_NEURONS),
    parameter int unsigned REFRACT_STEPS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   cur_wr_en,
    input  logic [AW-1:0]          cur_wr_addr,
    input  logic [DW-1:0]          cur_wr_data,
    output logic                   dp_req,
    output logic [DW-1:0]          dp_mem,
    output logic [DW-1:0]          dp_cur,
    input  logic                   dp_ack,
    input  logic [DW-1:0]          dp_mem_next,
    input  logic                   dp_spike,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   spike_valid,
    output logic                   busy,
    output logic                   overrun
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q;
    logic [AW-1:0]          idx_q;
    logic [DW-1:0]          mem_q [NUM_NEURONS];
    logic [DW-1:0]          cur_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spike_acc_q;
    logic [NUM_NEURONS-1:0] spike_acc_d;
    logic [NUM_NEURONS-1:0] spike_vec_q;

    logic step_skip;   // current neuron is refractory: no request, advance in one cycle
    logic step_done;   // current neuron finishes this cycle
    logic last_idx;

`ifdef REFRACTORY_EN
    localparam int unsigned RW = $clog2(REFRACT_STEPS + 1);
    logic [RW-1:0] ref_q [NUM_NEURONS];

    assign step_skip = (state_q == StRun) && (ref_q[idx_q] != '0);
`else
    logic unused_cfg;

    assign unused_cfg = (REFRACT_STEPS == 0);
    assign step_skip  = 1'b0;
`endif

    assign step_done = (state_q == StRun) && (step_skip || dp_ack);
    assign last_idx  = (idx_q == AW'(NUM_NEURONS - 1));

    // Accumulated spikes including the neuron finishing this cycle, so the final
    // writeback can load spike_vec directly and it is valid during the DONE cycle.
    always_comb begin
        spike_acc_d        = spike_acc_q;
        spike_acc_d[idx_q] = !step_skip && dp_spike;
    end

    assign dp_req      = (state_q == StRun) && !step_skip;
    assign dp_mem      = mem_q[idx_q];
    assign dp_cur      = cur_q[idx_q];
    assign busy        = (state_q == StRun);
    assign spike_valid = (state_q == StDone);
    assign overrun     = tick && (state_q != StIdle);
    assign spike_vec   = spike_vec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            spike_acc_q <= '0;
            spike_vec_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem_q[i] <= '0;
                cur_q[i] <= '0;
`ifdef REFRACTORY_EN
                ref_q[i] <= '0;
`endif
            end
        end else begin
            if (cur_wr_en) begin
                cur_q[cur_wr_addr] <= cur_wr_data;
            end

            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q     <= StRun;
                        idx_q       <= '0;
                        spike_acc_q <= '0;
                    end
                end
                StRun: begin
                    if (step_done) begin
                        mem_q[idx_q] <= step_skip ? '0 : dp_mem_next;
                        spike_acc_q  <= spike_acc_d;
`ifdef REFRACTORY_EN
                        if (step_skip) begin
                            ref_q[idx_q] <= ref_q[idx_q] - 1'b1;
                        end else if (dp_spike) begin
                            ref_q[idx_q] <= RW'(REFRACT_STEPS);
                        end
`endif
                        if (last_idx) begin
                            state_q     <= StDone;
                            spike_vec_q <= spike_acc_d;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_step_scheduler.sv
// tb_lif_step_scheduler
//   Directed bench for lif_step_scheduler. A behavioural LIF datapath answers requests with a
//   programmable ack delay; an independent neuron model predicts every request and spike vector
//   into queues that a monitor pops as the DUT produces them.

module tb_lif_step_scheduler;

    localparam int N = 4;
    localparam int REFRACT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       cur_wr_en = 1'b0;
    logic [1:0] cur_wr_addr = '0;
    logic [7:0] cur_wr_data = '0;
    logic       dp_req;
    logic [7:0] dp_mem;
    logic [7:0] dp_cur;
    logic       dp_ack = 1'b0;
    logic [7:0] dp_mem_next = '0;
    logic       dp_spike = 1'b0;
    logic [3:0] spike_vec;
    logic       spike_valid;
    logic       busy;
    logic       overrun;

    lif_step_scheduler #(
        .NUM_NEURONS  (N),
        .DW           (8),
        .REFRACT_STEPS(REFRACT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .cur_wr_en  (cur_wr_en),
        .cur_wr_addr(cur_wr_addr),
        .cur_wr_data(cur_wr_data),
        .dp_req     (dp_req),
        .dp_mem     (dp_mem),
        .dp_cur     (dp_cur),
        .dp_ack     (dp_ack),
        .dp_mem_next(dp_mem_next),
        .dp_spike   (dp_spike),
        .spike_vec  (spike_vec),
        .spike_valid(spike_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] mem; logic [7:0] cur; } req_t;
    typedef struct { logic [3:0] vec; int cyc; } spk_t;

    req_t req_q[$];
    spk_t spike_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    int n_valid = 0;
    int exp_valid = 0;
    int n_overrun = 0;
    int n_acks = 0;

    int m_mem [N];
    int m_cur [N];
    int m_ref [N];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural datapath: next = mem - mem/2 + cur, fire and reset at >= 200.
    always @(negedge clk) begin
        int nxt;
        if (dp_req) begin
            if (wait_cnt == ack_delay) begin
                nxt = int'(dp_mem) - int'(dp_mem >> 1) + int'(dp_cur);
                dp_ack   = 1'b1;
                dp_spike = (nxt >= 200);
                dp_mem_next = (nxt >= 200) ? 8'd0 : nxt[7:0];
                wait_cnt = 0;
            end else begin
                dp_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            dp_ack   = 1'b0;
            dp_spike = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor: every request cycle (including ack waits) must match the predicted head.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (dp_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", dp_req, 0);
                end else begin
                    check("dp_mem", dp_mem, req_q[0].mem);
                    check("dp_cur", dp_cur, req_q[0].cur);
                    if (dp_ack) begin
                        void'(req_q.pop_front());
                        n_acks++;
                    end
                end
            end
            if (spike_valid) begin
                n_valid++;
                if (spike_q.size() == 0) begin
                    check("unexpected_valid", spike_valid, 0);
                end else begin
                    check("spike_vec", spike_vec, spike_q[0].vec);
                    check("spike_latency", cyc, spike_q[0].cyc);
                    void'(spike_q.pop_front());
                end
            end
            if (overrun) n_overrun++;
        end
    end

    task automatic reset_model();
        req_q.delete();
        spike_q.delete();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = 0;
            m_cur[i] = 0;
            m_ref[i] = 0;
        end
    endtask

    task automatic write_cur(input int addr, input int data);
        @(negedge clk);
        cur_wr_en   = 1'b1;
        cur_wr_addr = addr[1:0];
        cur_wr_data = data[7:0];
        m_cur[addr] = data;
        @(negedge clk);
        cur_wr_en = 1'b0;
    endtask

    // Predicts one full timestep, then pulses tick from IDLE.
    task automatic do_tick(input int delay);
        req_t r;
        spk_t s;
        int lat;
        int nxt;
        logic [3:0] acc;
        @(negedge clk);
        ack_delay = delay;
        lat = 0;
        acc = '0;
        for (int i = 0; i < N; i++) begin
`ifdef REFRACTORY_EN
            if (m_ref[i] != 0) begin
                m_mem[i] = 0;
                m_ref[i]--;
                lat++;
                continue;
            end
`endif
            r.mem = m_mem[i][7:0];
            r.cur = m_cur[i][7:0];
            req_q.push_back(r);
            nxt = m_mem[i] - (m_mem[i] >> 1) + m_cur[i];
            if (nxt >= 200) begin
                acc[i]   = 1'b1;
                nxt      = 0;
                m_ref[i] = REFRACT;
            end
            m_mem[i] = nxt;
            lat += delay + 1;
        end
        s.vec = acc;
        s.cyc = cyc + lat + 1;
        spike_q.push_back(s);
        exp_valid++;
        tick = 1'b1;
        #2;
        check("idle_tick_no_overrun", overrun, 0);
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (req_q.size() == 0 && spike_q.size() == 0) break;
            @(negedge clk);
        end
        check("wait_idle_residue", req_q.size() + spike_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        reset_model();

        // 1: reset state, then a step from all-zero registers
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_dp_req", dp_req, 0);
        check("rst_busy", busy, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_spike_vec", spike_vec, 0);
        check("rst_overrun", overrun, 0);
        do_tick(0);
        #2;
        check("busy_in_run", busy, 1);
        wait_idle();

        // 2: n0 integrates, no spikes; following step shows its membrane
        write_cur(0, 10);
        do_tick(0);
        wait_idle();
        do_tick(0);
        wait_idle();

        // 3: n2 driven over threshold
        write_cur(2, 250);
        do_tick(0);
        wait_idle();
        do_tick(0);
        wait_idle();

        // 4: slow datapath, 3 wait cycles per request
        write_cur(2, 0);
        write_cur(1, 60);
        do_tick(3);
        wait_idle();

        // 5: tick during RUN is an overrun and starts nothing
        a0 = n_valid;
        do_tick(3);
        repeat (2) @(negedge clk);
        tick = 1'b1;
        #2;
        check("overrun_pulse", overrun, 1);
        @(negedge clk);
        tick = 1'b0;
        #2;
        check("overrun_cleared", overrun, 0);
        wait_idle();
        repeat (4) @(negedge clk);
        check("one_valid_per_step", n_valid - a0, 1);
        check("overrun_count", n_overrun, 1);

        // 6: reset during the second request discards the timestep
        write_cur(3, 40);
        do_tick(0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        exp_valid--;
        #2;
        check("rst_mid_dp_req", dp_req, 0);
        check("rst_mid_busy", busy, 0);
        a0 = n_valid;
        repeat (8) @(negedge clk);
        check("no_valid_after_rst", n_valid - a0, 0);
        write_cur(1, 50);
        do_tick(0);
        wait_idle();

`ifdef REFRACTORY_EN
        // 7: n2 fires, then sits out two steps
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        write_cur(2, 250);
        do_tick(0);
        wait_idle();
        for (int s = 0; s < 3; s++) begin
            a0 = n_acks;
            do_tick(0);
            wait_idle();
            check("refr_req_count", n_acks - a0, (s < 2) ? 3 : 4);
        end
`endif

        check("valid_total", n_valid, exp_valid);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
